// File: rtl/onewire_pkg.sv
// onewire_pkg: command/state enums and normal/overdrive slot timing tables {low, smp, fin} in ticks, indexed by op
package onewire_pkg;
  typedef enum logic [1:0] {OP_W0, OP_W1, OP_RST, OP_PWR} op_t;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, PWR} st_t;
  typedef struct packed {
    logic [9:0] low;
    logic [9:0] smp;
    logic [9:0] fin;
  } tim_t;
  localparam tim_t TIM_N [4] = '{
    '{10'd60,  10'd60,  10'd70},
    '{10'd6,   10'd15,  10'd70},
    '{10'd480, 10'd550, 10'd960},
    '{10'd0,   10'd0,   10'd0}
  };
  localparam tim_t TIM_O [4] = '{
    '{10'd30,  10'd30,  10'd40},
    '{10'd4,   10'd8,   10'd40},
    '{10'd280, 10'd314, 10'd576},
    '{10'd0,   10'd0,   10'd0}
  };
endpackage

// File: rtl/onewire_master_link_sync_pre.sv
// onewire_sync_pre: 2-FF line synchronizer and slot tick prescaler (clk, rst_n, ovd, clr, owr_i -> owr_s, tick)
module onewire_sync_pre #(
  parameter int PRE_N = 50,
  parameter int PRE_O = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ovd,
  input  logic clr,
  input  logic owr_i,
  output logic owr_s,
  output logic tick
);
  localparam int PM = PRE_N > PRE_O ? PRE_N : PRE_O;
  localparam int PW = $clog2(PM);
  logic [1:0] r_sync;
  logic [PW-1:0] r_pre;
  logic [PW-1:0] w_lim;
  assign w_lim = PW'(ovd ? PRE_O - 1 : PRE_N - 1);
  assign owr_s = r_sync[1];
  assign tick = !clr && r_pre == w_lim;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync <= 2'b11;
      r_pre <= '0;
    end else begin
      r_sync <= {r_sync[0], owr_i};
      r_pre <= (clr || tick) ? '0 : r_pre + 1'b1;
    end
endmodule

// File: rtl/onewire_master_link.sv
// onewire_master_link: 1-wire master slot engine (cmd_vld/rdy/op/ovd in, rsp_vld/dat + busy out, owr_e/owr_p drive, owr_i sense)
module onewire_master_link
  import onewire_pkg::*;
#(
  parameter int PRE_N = 50,
  parameter int PRE_O = 12,
  parameter int CNW = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_vld,
  output logic       cmd_rdy,
  input  logic [1:0] cmd_op,
  input  logic       cmd_ovd,
  output logic       rsp_vld,
  output logic       rsp_dat,
  output logic       busy,
  output logic       owr_e,
  output logic       owr_p,
  input  logic       owr_i
);
  st_t r_st, w_nxt;
  op_t r_op;
  tim_t w_t;
  logic r_ovd, r_dat, w_acc, w_pacc, w_tick, w_s, w_hl, w_hs, w_hf;
  logic [CNW-1:0] r_cnt, w_cn1;
  onewire_sync_pre #(.PRE_N(PRE_N), .PRE_O(PRE_O)) u_sp (
    .clk(clk), .rst_n(rst_n), .ovd(r_ovd), .clr(w_acc), .owr_i(owr_i), .owr_s(w_s), .tick(w_tick)
  );
  assign cmd_rdy = r_st == IDLE || r_st == PWR;
  assign busy = r_st == LOW || r_st == HIGH;
  assign owr_e = r_st == LOW;
  assign owr_p = r_st == PWR;
  assign w_acc = cmd_vld && cmd_rdy;
  assign w_pacc = w_acc && op_t'(cmd_op) == OP_PWR;
  assign w_t = r_ovd ? TIM_O[r_op] : TIM_N[r_op];
  assign w_cn1 = r_cnt + 1'b1;
  // events fire on the tick that moves the counter onto the threshold
  assign w_hl = w_tick && w_cn1 == CNW'(w_t.low);
  assign w_hs = w_tick && w_cn1 == CNW'(w_t.smp);
  assign w_hf = w_tick && w_cn1 == CNW'(w_t.fin);
  assign rsp_vld = w_pacc || (r_st == HIGH && w_hf);
  assign rsp_dat = w_pacc ? w_s : r_dat;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_st <= IDLE;
    else r_st <= w_nxt;
  always_comb begin
    w_nxt = r_st;
    case (r_st)
      IDLE, PWR: if (w_acc) w_nxt = op_t'(cmd_op) == OP_PWR ? PWR : LOW;
      LOW: if (w_hl) w_nxt = HIGH;
      HIGH: if (w_hf) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_op <= OP_W0;
      r_ovd <= 1'b0;
      r_cnt <= '0;
      r_dat <= 1'b1;
    end else begin
      if (w_acc) begin
        r_op <= op_t'(cmd_op);
        r_ovd <= cmd_ovd;
      end
      r_cnt <= w_acc ? '0 : w_tick ? w_cn1 : r_cnt;
      if (w_pacc || (busy && w_hs)) r_dat <= w_s;
    end
  assert property (@(posedge clk) disable iff (!rst_n) !(owr_e && owr_p));
endmodule

// File: doc/onewire_master_link.md
Name: onewire_master_link

Overview:
- Synthesizable 1-wire master link layer: the block that drives `owr` in place of the behavioural master model on the shared pulled-up line.
- Accepts one command at a time (reset/presence, write-0, write-1/read, strong-pullup power) over a valid/ready handshake.
- Generates normal or overdrive slot timing from a prescaled tick.
- Returns one sampled bit per command to the host-side register block.

Parameters:
- PRE_N, 50, clock cycles per normal-mode tick (1 us); must be >= 2.
- PRE_O, 12, clock cycles per overdrive tick (0.25 us); must be >= 2.
- CNW, 10, width of slot tick counter; must hold 960.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- cmd_vld  input  1  command valid
- cmd_rdy  output  1  command ready; high only in IDLE or PWR
- cmd_op  input  2  0=write-0, 1=write-1/read, 2=reset/presence, 3=power
- cmd_ovd  input  1  1=overdrive timing for this command
- rsp_vld  output  1  one-cycle pulse at end of slot
- rsp_dat  output  1  sampled line value; held until next rsp_vld
- busy  output  1  high from command accept until rsp_vld, inclusive
- owr_e  output  1  1=pull line low (open-drain enable)
- owr_p  output  1  1=strong pullup active
- owr_i  input  1  line level, asynchronous

Behaviour:
- Reset values: cmd_rdy=1, rsp_vld=0, rsp_dat=1, busy=0, owr_e=0, owr_p=0, sync FFs=1.
- owr_e and owr_p are cleared by the asynchronous reset edge, not on a clock, so the line is released immediately.
- owr_i passes through a 2-FF synchronizer (reset to 1). All samples use the synchronized value, adding 2 clk to the effective sample point.
- Tick prescaler:
  - Prescaler reloads on command accept.
  - Emits a one-cycle tick every PRE_N or PRE_O cycles, selected by the latched cmd_ovd.
  - Slot counter `cnt` clears on accept and increments on tick.
- Timing constants, as (low end, sample, slot end) in ticks:
  - Normal (1 us ticks): reset 480/550/960; write-0 60/-/70; write-1/read 6/15/70.
  - Overdrive (0.25 us ticks): reset 280/314/576; write-0 30/-/40; write-1/read 4/8/40.
- FSM states: IDLE, LOW, HIGH, PWR.
  - IDLE: accept when cmd_vld&cmd_rdy; latch op and ovd.
    - op 0..2 -> LOW with owr_e=1 on the next clk, busy=1.
    - op 3 -> PWR with owr_p=1 on the next clk and busy=0; rsp_vld pulses the same cycle with rsp_dat=owr sync.
  - LOW: when cnt reaches low end, owr_e=0 and go to HIGH.
  - HIGH:
    - At the tick where cnt reaches sample, latch rsp_dat from the synchronized line.
    - write-0 latches at low end instead.
    - At slot end, pulse rsp_vld, busy=0, go to IDLE.
  - PWR: owr_p stays 1, cmd_rdy=1. Any accepted command clears owr_p in the same edge it sets owr_e. An op 3 in PWR re-pulses rsp_vld and stays.
- Commands are never queued; cmd_vld while busy is ignored and cmd_rdy=0.
- owr_e and owr_p are never both 1; an assertion checks this.
- Reset mid-slot: all state returns to reset values, no rsp_vld is emitted, and the partial slot is discarded.
- Line held low by a slave beyond the slot: no stretch. Timing is master-only, and rsp_dat reflects the sampled value.

Decomposition:
- onewire_pkg holds:
  - the op enum (OP_W0, OP_W1, OP_RST, OP_PWR);
  - the FSM state enum;
  - a timing struct {low, smp, fin} and two constant arrays, indexed by op, for normal and overdrive.
- One sub-module, onewire_sync_pre:
  - 2-FF synchronizer plus tick prescaler;
  - ports: clk, rst_n, ovd, clr, owr_i, owr_s, tick.

Test Plan:
- Normal reset with one slave present -> owr_e high for 480 ticks (24000 clk @PRE_N=50), rsp_dat=0, rsp_vld at tick 960; with slave disconnected -> rsp_dat=1.
- Normal write-0 -> owr_e high 60 ticks, slave captures 0, rsp_dat=0. Write-1 with slave read bit=1 -> owr_e high 6 ticks, rsp_dat=1. Slave read bit=0 -> rsp_dat=0.
- Overdrive write-1/read, slave driving 0 -> owr_e high 4 ticks (48 clk @PRE_O=12), rsp_vld at tick 40, rsp_dat=0.
- Power op, then write-1 -> owr_p=1 with cmd_rdy=1; owr_p drops on the same edge owr_e rises; never both high.
- cmd_vld pulsed during an active slot -> cmd_rdy=0, command ignored, exactly one rsp_vld.
- rst_n asserted mid reset-low (tick 200) -> owr_e=0 asynchronously before the next clk edge, no rsp_vld, IDLE with cmd_rdy=1 after release.
